// File: rtl/lockstep_equiv_checker_pkg.sv
// Shared types and helpers for the lockstep equivalence checker.
package lockstep_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRun,
        StDrain,
        StPass,
        StFail
    } checker_state_e;

    function automatic int unsigned num_cases(input int unsigned n);
        return 32'd1 << n;
    endfunction

endpackage

// File: rtl/lockstep_equiv_checker_if.sv
// Stimulus/compare/status bundle between the checker and the modules it exercises.
interface lockstep_equiv_checker_if #(
    parameter int unsigned NUM_INPUT_BITS = 2,
    parameter int unsigned OUT_WIDTH      = 1
);
    logic                      start;
    logic [NUM_INPUT_BITS-1:0] stim;
    logic [OUT_WIDTH-1:0]      out_gt;
    logic [OUT_WIDTH-1:0]      out_test;
    logic                      busy;
    logic                      done;
    logic                      pass;
    logic [NUM_INPUT_BITS-1:0] fail_inputs;
    logic [OUT_WIDTH-1:0]      fail_expected;
    logic [OUT_WIDTH-1:0]      fail_actual;
    logic [NUM_INPUT_BITS:0]   compared_count;
    logic [NUM_INPUT_BITS:0]   num_test_cases;

    modport master (
        input  start, out_gt, out_test,
        output stim, busy, done, pass, fail_inputs, fail_expected, fail_actual,
               compared_count, num_test_cases
    );

    modport slave (
        output start, out_gt, out_test,
        input  stim, busy, done, pass, fail_inputs, fail_expected, fail_actual,
               compared_count, num_test_cases
    );
endinterface

// File: rtl/lockstep_equiv_checker_valid_delay_line.sv
// Fixed-latency {valid, vector} pipe that lines each issued vector up with the module outputs.
module valid_delay_line #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic             pending_o
);
    if (DEPTH == 0) begin : g_wire
        assign valid_o   = valid_i;
        assign data_o    = data_i;
        assign pending_o = 1'b0;
    end else begin : g_regs
        logic [DEPTH-1:0] vld_q;
        logic [WIDTH-1:0] dat_q [DEPTH];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q <= '0;
                for (int i = 0; i < DEPTH; i++) dat_q[i] <= '0;
            end else if (clr_i) begin
                vld_q <= '0;
            end else begin
                vld_q[0] <= valid_i;
                dat_q[0] <= data_i;
                for (int i = 1; i < DEPTH; i++) begin
                    vld_q[i] <= vld_q[i-1];
                    dat_q[i] <= dat_q[i-1];
                end
            end
        end

        // Anything still in flight behind the stage currently being compared.
        always_comb begin
            pending_o = valid_i;
            for (int i = 0; i < DEPTH - 1; i++) pending_o = pending_o | vld_q[i];
        end

        assign valid_o = vld_q[DEPTH-1];
        assign data_o  = dat_q[DEPTH-1];
    end
endmodule

// File: rtl/lockstep_equiv_checker.sv
// Exhaustively drives a shared vector into two modules and compares their outputs after a
// fixed pipeline latency, stopping on and latching the first mismatch.
module lockstep_equiv_checker
    import lockstep_pkg::*;
#(
    parameter int unsigned NUM_INPUT_BITS = 2,
    parameter int unsigned OUT_WIDTH      = 1,
    parameter int unsigned PIPELINE_DEPTH = 2
) (
    input logic                      clk,
    input logic                      rst_n,
    lockstep_equiv_checker_if.master bus
);
    localparam int unsigned N        = NUM_INPUT_BITS;
    localparam logic [N:0]  NumCases = (N + 1)'(num_cases(N));

    checker_state_e       state_q, state_d;
    logic [N:0]           cnt_q, cnt_d;
    logic [N-1:0]         stim_q, stim_d;
    logic [N-1:0]         fail_in_q, fail_in_d;
    logic [OUT_WIDTH-1:0] fail_exp_q, fail_exp_d;
    logic [OUT_WIDTH-1:0] fail_act_q, fail_act_d;
    logic [N:0]           cmp_q, cmp_d;

    logic         chain_valid, chain_pending, active, start_ok, mismatch, match;
    logic [N-1:0] chain_data;

    assign active   = (state_q == StRun) || (state_q == StDrain);
    assign start_ok = bus.start && !active;
    assign mismatch = active && chain_valid && (bus.out_gt != bus.out_test);
    assign match    = active && chain_valid && (bus.out_gt == bus.out_test);

    valid_delay_line #(
        .WIDTH(N),
        .DEPTH(PIPELINE_DEPTH)
    ) u_delay (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (start_ok),
        .valid_i  (state_q == StRun),
        .data_i   (stim_q),
        .valid_o  (chain_valid),
        .data_o   (chain_data),
        .pending_o(chain_pending)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        stim_d     = stim_q;
        fail_in_d  = fail_in_q;
        fail_exp_d = fail_exp_q;
        fail_act_d = fail_act_q;
        cmp_d      = cmp_q;
        unique case (state_q)
            StIdle, StPass, StFail: begin
                if (start_ok) begin
                    // Vector 0 goes out on the start edge itself.
                    state_d    = StRun;
                    stim_d     = '0;
                    cnt_d      = (N + 1)'(1);
                    fail_in_d  = '0;
                    fail_exp_d = '0;
                    fail_act_d = '0;
                    cmp_d      = '0;
                end
            end
            StRun, StDrain: begin
                if (mismatch) begin
                    state_d    = StFail;
                    fail_in_d  = chain_data;
                    fail_exp_d = bus.out_gt;
                    fail_act_d = bus.out_test;
                end else begin
                    if (match) cmp_d = cmp_q + 1'b1;
                    if (state_q == StRun && cnt_q != NumCases) begin
                        stim_d = cnt_q[N-1:0];
                        cnt_d  = cnt_q + 1'b1;
                    end else begin
                        state_d = chain_pending ? StDrain : StPass;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            stim_q     <= '0;
            fail_in_q  <= '0;
            fail_exp_q <= '0;
            fail_act_q <= '0;
            cmp_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            stim_q     <= stim_d;
            fail_in_q  <= fail_in_d;
            fail_exp_q <= fail_exp_d;
            fail_act_q <= fail_act_d;
            cmp_q      <= cmp_d;
        end
    end

    assign bus.stim           = stim_q;
    assign bus.busy           = active;
    assign bus.done           = (state_q == StPass) || (state_q == StFail);
    assign bus.pass           = (state_q == StPass);
    assign bus.fail_inputs    = fail_in_q;
    assign bus.fail_expected  = fail_exp_q;
    assign bus.fail_actual    = fail_act_q;
    assign bus.compared_count = cmp_q;
    assign bus.num_test_cases = NumCases;
endmodule

// File: tb/tb_lockstep_equiv_checker.sv
// Bench: a 2-stage-deep and a combinational checker instance against a behavioural
// timeline model, with directed scenarios plus randomized truth tables, starts and resets.
module tb_lockstep_equiv_checker;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic [3:0] tt  = 4'b1000;  // test module truth table, index = {a,b}
    logic [3:0] tt0 = 4'b1000;
    logic g1 = 1'b0, g2 = 1'b0, t1 = 1'b0, t2 = 1'b0;
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    lockstep_equiv_checker_if #(.NUM_INPUT_BITS(2), .OUT_WIDTH(1)) ifa ();
    lockstep_equiv_checker_if #(.NUM_INPUT_BITS(2), .OUT_WIDTH(1)) ifb ();

    lockstep_equiv_checker #(.NUM_INPUT_BITS(2), .OUT_WIDTH(1), .PIPELINE_DEPTH(2)) u_dut_a (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (ifa)
    );
    lockstep_equiv_checker #(.NUM_INPUT_BITS(2), .OUT_WIDTH(1), .PIPELINE_DEPTH(0)) u_dut_b (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (ifb)
    );

    // Modules under comparison: 2-stage AND vs 2-stage table, and combinational pair.
    always @(posedge clk) begin
        g1 <= &ifa.stim;
        g2 <= g1;
        t1 <= tt[ifa.stim];
        t2 <= t1;
    end
    assign ifa.start    = start;
    assign ifa.out_gt   = g2;
    assign ifa.out_test = t2;
    assign ifb.start    = start;
    assign ifb.out_gt   = &ifb.stim;
    assign ifb.out_test = tt0[ifb.stim];

    // Model: per checker, edges since the accepted start and the first failing vector.
    bit       m_started[2];
    int       m_t[2];
    int       m_fk[2];
    logic [3:0] m_tt[2];

    function automatic int depth_of(input int i);
        return (i == 0) ? 2 : 0;
    endfunction

    function automatic int first_fail(input logic [3:0] table_v);
        for (int j = 0; j < 4; j++) if (table_v[j] != (j == 3)) return j;
        return 4;
    endfunction

    function automatic int end_edge(input int d, input int fk);
        return (fk < 4) ? fk + d + 1 : 4 + d;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) m_started[i] <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (start && (!m_started[i] || m_t[i] >= end_edge(depth_of(i), m_fk[i]))) begin
                    m_started[i] <= 1'b1;
                    m_t[i]       <= 0;
                    m_fk[i]      <= first_fail((i == 0) ? tt : tt0);
                    m_tt[i]      <= (i == 0) ? tt : tt0;
                end else if (m_started[i]) begin
                    m_t[i] <= m_t[i] + 1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_dut(input int i, input logic [1:0] stim, input logic busy,
                             input logic done, input logic pass, input logic [1:0] fi,
                             input logic fe, input logic fa, input logic [2:0] cc,
                             input logic [2:0] nt);
        int d, t, fk, eend, lim, e_stim, e_cc;
        int e_busy, e_done, e_pass, e_fi, e_fe, e_fa;
        d = depth_of(i);
        t = m_t[i];
        fk = m_fk[i];
        eend = end_edge(d, fk);
        lim = (fk < 4) ? fk : 4;
        {e_stim, e_cc, e_busy, e_done, e_pass, e_fi, e_fe, e_fa} = '0;
        if (m_started[i]) begin
            e_stim = t;
            if (e_stim > eend - 1) e_stim = eend - 1;
            if (e_stim > 3) e_stim = 3;
            e_busy = (t < eend) ? 1 : 0;
            e_done = 1 - e_busy;
            e_pass = (e_done == 1 && fk == 4) ? 1 : 0;
            e_cc = t - d;
            if (e_cc < 0) e_cc = 0;
            if (e_cc > lim) e_cc = lim;
            if (fk < 4 && t >= eend) begin
                e_fi = fk;
                e_fe = (fk == 3) ? 1 : 0;
                e_fa = int'(m_tt[i][fk]);
            end
        end
        chk($sformatf("dut%0d.stim", i), 32'(stim), e_stim);
        chk($sformatf("dut%0d.busy", i), 32'(busy), e_busy);
        chk($sformatf("dut%0d.done", i), 32'(done), e_done);
        chk($sformatf("dut%0d.pass", i), 32'(pass), e_pass);
        chk($sformatf("dut%0d.fail_inputs", i), 32'(fi), e_fi);
        chk($sformatf("dut%0d.fail_expected", i), 32'(fe), e_fe);
        chk($sformatf("dut%0d.fail_actual", i), 32'(fa), e_fa);
        chk($sformatf("dut%0d.compared_count", i), 32'(cc), e_cc);
        chk($sformatf("dut%0d.num_test_cases", i), 32'(nt), 4);
    endtask

    always @(negedge clk) begin
        check_dut(0, ifa.stim, ifa.busy, ifa.done, ifa.pass, ifa.fail_inputs,
                  ifa.fail_expected, ifa.fail_actual, ifa.compared_count, ifa.num_test_cases);
        check_dut(1, ifb.stim, ifb.busy, ifb.done, ifb.pass, ifb.fail_inputs,
                  ifb.fail_expected, ifb.fail_actual, ifb.compared_count, ifb.num_test_cases);
    end

    // Start is sampled on the edge after it is raised; returns just after that edge (E0).
    task automatic pulse_start();
        @(posedge clk);
        #2 start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #3;
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while ((ifa.busy || ifb.busy) && k < budget) begin
            @(posedge clk);
            #3;
            k++;
        end
        chk("wait_idle_timeout", 32'(ifa.busy | ifb.busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #12 rst_n = 1'b1;
        wait_edges(2);
        chk("reset.done", 32'(ifa.done), 0);

        // Identical 2-stage AND: pass after E6, busy through E5.
        tt = 4'b1000; tt0 = 4'b1000;
        pulse_start();
        chk("s1.busy_e0", 32'(ifa.busy), 1);
        wait_edges(5);
        chk("s1.busy_e5", 32'(ifa.busy), 1);
        wait_edges(1);
        chk("s1.pass", 32'(ifa.pass), 1);
        chk("s1.count", 32'(ifa.compared_count), 4);

        // ~a|~b fails on vector 0; comb AND vs XOR fails on vector 1 after E2.
        tt = 4'b0111; tt0 = 4'b0110;
        pulse_start();
        wait_edges(2);
        chk("s4.done", 32'(ifb.done), 1);
        chk("s4.fail_inputs", 32'(ifb.fail_inputs), 1);
        chk("s4.fail_actual", 32'(ifb.fail_actual), 1);
        wait_edges(1);
        chk("s2.done", 32'(ifa.done), 1);
        chk("s2.fail_inputs", 32'(ifa.fail_inputs), 0);
        chk("s2.fail_actual", 32'(ifa.fail_actual), 1);
        chk("s2.pass", 32'(ifa.pass), 0);
        wait_edges(3);
        chk("s2.stim_frozen", 32'(ifa.stim), 2);

        // Fixed module swapped in: restart clears the latches on the start edge.
        tt = 4'b1000; tt0 = 4'b1000;
        pulse_start();
        chk("s6.fail_actual_cleared", 32'(ifa.fail_actual), 0);
        wait_edges(6);
        chk("s6.pass", 32'(ifa.pass), 1);
        chk("s6.count", 32'(ifa.compared_count), 4);

        // Differs only on the last vector: caught while draining.
        tt = 4'b0000;
        pulse_start();
        wait_edges(6);
        chk("s3.fail_inputs", 32'(ifa.fail_inputs), 3);
        chk("s3.fail_expected", 32'(ifa.fail_expected), 1);
        chk("s3.count", 32'(ifa.compared_count), 3);

        // Reset while vector 2 is on stim, then a clean run with the same timing.
        tt = 4'b1000;
        pulse_start();
        wait_edges(2);
        chk("s5.stim_before_reset", 32'(ifa.stim), 2);
        rst_n = 1'b0;
        #1;
        chk("s5.busy_reset", 32'(ifa.busy), 0);
        chk("s5.stim_reset", 32'(ifa.stim), 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        pulse_start();
        wait_edges(5);
        chk("s5.busy_e5", 32'(ifa.busy), 1);
        wait_edges(1);
        chk("s5.pass", 32'(ifa.pass), 1);

        // Randomized truth tables with stray starts and occasional resets.
        for (int r = 0; r < 30; r++) begin
            wait_idle(40);
            tt  = 4'($urandom);
            tt0 = 4'($urandom);
            pulse_start();
            for (int c = 0; c < int'($urandom_range(2, 10)); c++) begin
                @(posedge clk);
                #2;
                start = ($urandom_range(0, 3) == 0);
                if ($urandom_range(0, 19) == 0) begin
                    rst_n = 1'b0;
                    @(posedge clk);
                    #2 rst_n = 1'b1;
                end
            end
            @(posedge clk);
            #2 start = 1'b0;
        end
        wait_idle(40);
        wait_edges(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
